// File: rtl/rs_pkg.sv
// Shared RS(15,9) codec types and defaults for the GF(16) datapath blocks.
// Holds the symbol/polynomial typedefs, the multiplier scheduler state
// encoding and the polynomial multiplier latency.
package rs_pkg;

  localparam int unsigned WORD_WIDTH = 4;
  localparam int unsigned N_NUM      = 6;

  // Edges from multiplier start to a valid product.
  localparam int unsigned PMUL_LAT   = N_NUM + 2;

  typedef logic [WORD_WIDTH-1:0] gf_word_t;
  typedef gf_word_t [N_NUM-1:0]  poly_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } pmul_state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: selects the first set request bit at or
// after ptr_i, wrapping around. Reusable by any shared GF resource.
// Ports:
//   req_i        request vector, one bit per requester
//   ptr_i        index with the highest priority this round
//   winner_oh_c  one-hot winner (all zero when no request)
//   winner_idx_c binary winner index (0 when no request)
//   valid_c      at least one request is pending
module rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  winner_oh_c,
  output logic [PW-1:0] winner_idx_c,
  output logic          valid_c
);

  // Scan N positions starting at ptr_i; the first hit wins.
  always_comb begin
    winner_oh_c  = '0;
    winner_idx_c = '0;
    valid_c      = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid_c && req_i[PW'((32'(ptr_i) + k) % N)]) begin
        valid_c      = 1'b1;
        winner_idx_c = PW'((32'(ptr_i) + k) % N);
        winner_oh_c[PW'((32'(ptr_i) + k) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmul_sched.sv
// Round-robin scheduler sharing one GF(16) polynomial multiplier between
// N_REQ requesters. Grants one requester, latches its operands, pulses the
// multiplier start, waits the fixed multiplier latency, captures the product
// and pulses done back to the owner.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_i         level requests, held until the matching done_o
//   opa_i, opb_i  per-requester operand polynomials
//   gnt_o         one-cycle grant pulse (operands latched on that edge)
//   done_o        one-cycle completion pulse to the owner
//   res_o         captured product, held until the next capture
//   busy_o        scheduler not idle
//   err_o         sticky: multiplier not ready at capture
//   mult_en_o     one-cycle multiplier start
//   mult_a_o/b_o  latched operands to the multiplier
//   mult_ready_i  multiplier ready status (status only, not timing)
//   mult_res_i    multiplier product
module pmul_sched
  import rs_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = rs_pkg::WORD_WIDTH,
  parameter int unsigned N_NUM      = rs_pkg::N_NUM,
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [N_REQ-1:0]                             req_i,
  input  logic [N_REQ-1:0][N_NUM-1:0][WORD_WIDTH-1:0]  opa_i,
  input  logic [N_REQ-1:0][N_NUM-1:0][WORD_WIDTH-1:0]  opb_i,
  output logic [N_REQ-1:0]                             gnt_o,
  output logic [N_REQ-1:0]                             done_o,
  output logic [N_NUM-1:0][WORD_WIDTH-1:0]             res_o,
  output logic                                         busy_o,
  output logic                                         err_o,
  output logic                                         mult_en_o,
  output logic [N_NUM-1:0][WORD_WIDTH-1:0]             mult_a_o,
  output logic [N_NUM-1:0][WORD_WIDTH-1:0]             mult_b_o,
  input  logic                                         mult_ready_i,
  input  logic [N_NUM-1:0][WORD_WIDTH-1:0]             mult_res_i
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [N_NUM-1:0][WORD_WIDTH-1:0] vec_t;

  pmul_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     done_q, done_d;
  vec_t                 res_q, res_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 mult_en_q, mult_en_d;
  vec_t                 mult_a_q, mult_a_d;
  vec_t                 mult_b_q, mult_b_d;

  logic [N_REQ-1:0]     win_oh_c;
  logic [PW-1:0]        win_idx_c;
  logic                 win_valid_c;

  rr_arb #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_arb (
    .req_i        (req_i),
    .ptr_i        (rr_ptr_q),
    .winner_oh_c  (win_oh_c),
    .winner_idx_c (win_idx_c),
    .valid_c      (win_valid_c)
  );

  // Next-state and output logic; pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    gnt_d     = '0;
    done_d    = '0;
    res_d     = res_q;
    err_d     = err_q;
    mult_en_d = 1'b0;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;

    unique case (state_q)
      IDLE: begin
        if (win_valid_c) begin
          owner_d   = win_idx_c;
          mult_a_d  = opa_i[win_idx_c];
          mult_b_d  = opb_i[win_idx_c];
          gnt_d     = win_oh_c;
          mult_en_d = 1'b1;
          rr_ptr_d  = (32'(win_idx_c) == N_REQ - 1) ? '0 : PW'(win_idx_c + PW'(1));
          state_d   = START;
        end
      end
      START: begin
        // Reloaded here every job, so the down-counter never wraps.
        cnt_d   = CNT_WIDTH'(N_NUM + 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_d           = mult_res_i;
          done_d[owner_q] = 1'b1;
          err_d           = err_q | ~mult_ready_i;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mult_en_q <= 1'b0;
      mult_a_q  <= '0;
      mult_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      mult_en_q <= mult_en_d;
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign res_o     = res_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign mult_en_o = mult_en_q;
  assign mult_a_o  = mult_a_q;
  assign mult_b_o  = mult_b_q;

endmodule

// File: tb/tb_pmul_sched.sv
// Self-checking bench for pmul_sched: a job-timeline reference model (cycles
// since grant) predicts every output each cycle; a behavioural GF(16)
// multiplier returns junk until its latency has elapsed.
module tb_pmul_sched;

  localparam int W = 4;
  localparam int N = 6;
  localparam int R = 2;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [R-1:0]               req_i = '0;
  logic [R-1:0][N-1:0][W-1:0] opa_i = '0;
  logic [R-1:0][N-1:0][W-1:0] opb_i = '0;
  logic [R-1:0]               gnt_o;
  logic [R-1:0]               done_o;
  vec_t                       res_o;
  logic                       busy_o;
  logic                       err_o;
  logic                       mult_en_o;
  vec_t                       mult_a_o;
  vec_t                       mult_b_o;
  logic                       mult_ready_i = 1'b1;
  vec_t                       mult_res_i = '0;

  pmul_sched #(
    .WORD_WIDTH (W),
    .N_NUM      (N),
    .N_REQ      (R),
    .CNT_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .opa_i        (opa_i),
    .opb_i        (opb_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .res_o        (res_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .mult_en_o    (mult_en_o),
    .mult_a_o     (mult_a_o),
    .mult_b_o     (mult_b_o),
    .mult_ready_i (mult_ready_i),
    .mult_res_i   (mult_res_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase = edges since grant (-1 when idle).
  int   m_phase = -1;
  int   m_owner = 0;
  int   m_rr    = 0;
  vec_t exp_a   = '0;
  vec_t exp_b   = '0;
  vec_t exp_res = '0;
  logic exp_err = 1'b0;

  // Multiplier model: edges since start (-1 when no job).
  int mc = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      // x^4 = x + 1 in GF(16)
      aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
    end
    return p;
  endfunction

  // Low N coefficients of the polynomial product.
  function automatic vec_t poly_mul(input vec_t a, input vec_t b);
    vec_t c;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= i; j++)
        c[i] = c[i] ^ gf_mul(a[j], b[i-j]);
    return c;
  endfunction

  function automatic logic [R-1:0] onehot(input int idx);
    logic [R-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs that edge saw.
  task automatic model_edge();
    if (m_phase < 0) begin
      if (req_i != '0) begin
        for (int k = R - 1; k >= 0; k--)
          if (req_i[(m_rr + k) % R]) m_owner = (m_rr + k) % R;
        exp_a   = opa_i[m_owner];
        exp_b   = opb_i[m_owner];
        m_rr    = (m_owner + 1) % R;
        m_phase = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == N + 3) begin
        exp_res = poly_mul(exp_a, exp_b);
        exp_err = exp_err | ~mult_ready_i;
      end
      if (m_phase == N + 4) m_phase = -1;
    end
  endtask

  task automatic check_all();
    check_eq("gnt",     64'(gnt_o),     64'((m_phase == 0) ? onehot(m_owner) : '0));
    check_eq("mult_en", 64'(mult_en_o), 64'(m_phase == 0));
    check_eq("done",    64'(done_o),    64'((m_phase == N + 3) ? onehot(m_owner) : '0));
    check_eq("busy",    64'(busy_o),    64'(m_phase >= 0));
    check_eq("mult_a",  64'(mult_a_o),  64'(exp_a));
    check_eq("mult_b",  64'(mult_b_o),  64'(exp_b));
    check_eq("res",     64'(res_o),     64'(exp_res));
    check_eq("err",     64'(err_o),     64'(exp_err));
  endtask

  // Multiplier: junk until the product is due just before the capture edge.
  task automatic mult_model();
    if (!rst_n) begin
      mc = -1;
      mult_res_i = '0;
    end else if (mult_en_o) begin
      mc = 0;
      mult_res_i = vec_t'($urandom);
    end else if (mc >= 0 && mc < N + 2) begin
      mc++;
      mult_res_i = (mc == N + 2) ? poly_mul(mult_a_o, mult_b_o) : vec_t'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    check_all();
    mult_model();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < R; i++) begin
      opa_i[i] = vec_t'($urandom);
      opb_i[i] = vec_t'($urandom);
    end
  endtask

  // Called at a negedge; asynchronous reset must clear outputs at once.
  task automatic do_reset();
    rst_n = 1'b0;
    req_i = '0;
    #1;
    m_phase = -1;
    m_rr    = 0;
    exp_a   = '0;
    exp_b   = '0;
    exp_res = '0;
    exp_err = 1'b0;
    check_all();
    mult_model();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  // Requester behaviour after each cycle, driven by the model's done.
  task automatic rand_reqs();
    for (int i = 0; i < R; i++) begin
      if (m_phase == N + 3 && m_owner == i) req_i[i] = ($urandom_range(0, 3) == 0);
      else if (!req_i[i]) req_i[i] = ($urandom_range(0, 3) == 0);
      else if (m_phase >= 0 && m_owner == i && $urandom_range(0, 15) == 0) req_i[i] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Single job with fixed operands: (1+2x)(3+x) = 3 + 7x + 2x^2.
    opa_i[0] = '0;
    opb_i[0] = '0;
    opa_i[0][0] = 4'h1;
    opa_i[0][1] = 4'h2;
    opb_i[0][0] = 4'h3;
    opb_i[0][1] = 4'h1;
    req_i = 2'b01;
    for (int k = 0; k < 12; k++) begin
      step();
      if (m_phase == N + 3) req_i[0] = 1'b0;
    end
    check_eq("golden_res", 64'(res_o), 64'h000273);

    // Reset while a job sits in WAIT: no done, clean restart.
    rand_ops();
    req_i = 2'b01;
    for (int k = 0; k < 5; k++) step();
    do_reset();

    // Contention with both requests held, operands churning every cycle.
    req_i = 2'b11;
    for (int k = 0; k < 33; k++) begin
      step();
      rand_ops();
    end
    req_i = '0;
    for (int k = 0; k < 12; k++) step();

    // Fairness: requester 0 re-asserts right after each done, 1 held.
    req_i = 2'b11;
    for (int k = 0; k < 44; k++) begin
      step();
      rand_ops();
      req_i[0] = !(m_phase == N + 3 && m_owner == 0);
    end
    req_i = '0;
    for (int k = 0; k < 12; k++) step();

    // Not-ready at one capture; later good jobs must keep err set.
    req_i = 2'b01;
    for (int k = 0; k < 33; k++) begin
      step();
      rand_ops();
      mult_ready_i = !(k < 11 && m_phase == N + 2);
    end
    check_eq("err_sticky", 64'(err_o), 64'(1));
    req_i = '0;
    for (int k = 0; k < 12; k++) step();
    do_reset();

    // Randomized traffic with occasional resets and not-ready captures.
    for (int k = 0; k < 600; k++) begin
      step();
      rand_ops();
      rand_reqs();
      mult_ready_i = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 249) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
